// File: rtl/pattern_random_pkg.sv
// ---------------------------------------------------------------------------
// pattern_random_pkg
// Shared constants and types for the random MAX7219 pattern generator:
//   - LFSR width, Galois tap mask and reset seed
//   - FSM state enum (IDLE / FILL)
//   - MAX7219 command-word field widths and a word-builder helper
// No ports (package).
// ---------------------------------------------------------------------------
package pattern_random_pkg;

  localparam int LFSR_W     = 32;
  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 32'hACE1_2468;

  localparam int ADDR_W     = 4;
  localparam int DATA_W     = 8;
  localparam int CMD_W      = 16;
  localparam int NUM_DIGITS = 8;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  // One single-bit Galois shift: the bit shifted out selects the tap XOR.
  function automatic logic [LFSR_W-1:0] lfsr_shift1(input logic [LFSR_W-1:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  // MAX7219 digit-register command: digit index d addresses register d+1.
  function automatic logic [CMD_W-1:0] digit_cmd(input int unsigned digit,
                                                 input logic [DATA_W-1:0] data);
    return {4'h0, ADDR_W'(digit + 1), data};
  endfunction

endpackage

// File: rtl/pattern_random_lfsr_byte_step.sv
// ---------------------------------------------------------------------------
// lfsr_byte_step
// Purely combinational advance of the 32-bit Galois LFSR by eight single-bit
// shifts, so a full fresh byte is available every clock.
// Ports:
//   cur_state  [31:0] in   current LFSR state
//   next_state [31:0] out  state after eight shifts (low byte = new random byte)
// ---------------------------------------------------------------------------
module lfsr_byte_step
  import pattern_random_pkg::*;
(
  input  logic [LFSR_W-1:0] cur_state,
  output logic [LFSR_W-1:0] next_state
);

  always_comb begin
    // NOTE: blocking '=' here so each unrolled shift sees the previous one's
    // result within the same evaluation; clocked state elsewhere uses '<='.
    next_state = cur_state;
    for (int i = 0; i < 8; i++) begin
      next_state = lfsr_shift1(next_state);
    end
  end

endmodule

// File: rtl/pattern_random.sv
// ---------------------------------------------------------------------------
// pattern_random
// Once per CLK_FREQ_HZ cycles, refills a frame buffer of 8*ROWS*COLUMNS bytes
// with pseudo-random data, one byte per clock, and presents every byte as a
// MAX7219 digit-register command word.
// Parameters:
//   DISP_ROWS, DISP_COLUMNS  display matrix of MAX7219 devices (>=1 each)
//   CLK_FREQ_HZ              clock cycles between refresh ticks (>=1)
// Ports:
//   i_Clk                 in   design clock, rising edge
//   i_Rst                 in   asynchronous reset, active low
//   o_MAX7219_DataStream  out  [digit][row][column] command words
//                              {4'h0, digit+1, frame byte}
// ---------------------------------------------------------------------------
module pattern_random
  import pattern_random_pkg::*;
#(
  parameter int DISP_ROWS    = 1,
  parameter int DISP_COLUMNS = 1,
  parameter int CLK_FREQ_HZ  = 100_000_000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  output logic [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][15:0] o_MAX7219_DataStream
);

  localparam int CNT_W = (CLK_FREQ_HZ > 1)  ? $clog2(CLK_FREQ_HZ)  : 1;
  localparam int ROW_W = (DISP_ROWS > 1)    ? $clog2(DISP_ROWS)    : 1;
  localparam int COL_W = (DISP_COLUMNS > 1) ? $clog2(DISP_COLUMNS) : 1;
  localparam int DIG_W = $clog2(NUM_DIGITS);

  logic [CNT_W-1:0]  tick_cnt_q;
  logic              tick;

  state_t            state_q, state_d;
  logic              fill_en;

  // Slot index k kept in its (digit, row, column) decomposition, so the
  // column is the fastest-moving field and no divider is needed.
  logic [DIG_W-1:0]  dig_idx_q;
  logic [ROW_W-1:0]  row_idx_q;
  logic [COL_W-1:0]  col_idx_q;
  logic              col_last, row_last, last_slot;

  logic [LFSR_W-1:0] lfsr_q, lfsr_next;

  logic [DATA_W-1:0] frame_q [NUM_DIGITS][DISP_ROWS][DISP_COLUMNS];

  // -------------------------------------------------------------------------
  // Free-running tick counter, independent of the FSM.
  // -------------------------------------------------------------------------
  assign tick = (tick_cnt_q == CNT_W'(CLK_FREQ_HZ - 1));

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register / next-state / outputs.
  // -------------------------------------------------------------------------
  assign col_last  = (col_idx_q == COL_W'(DISP_COLUMNS - 1));
  assign row_last  = (row_idx_q == ROW_W'(DISP_ROWS - 1));
  assign last_slot = col_last && row_last && (dig_idx_q == DIG_W'(NUM_DIGITS - 1));

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE: if (tick)      state_d = FILL;
      FILL: if (last_slot) state_d = IDLE;  // ticks during FILL are dropped
      default:             state_d = IDLE;
    endcase
  end

  always_comb begin
    fill_en = (state_q == FILL);
  end

  // -------------------------------------------------------------------------
  // Slot walker: column, then row, then digit. The final increment wraps all
  // three fields back to zero, leaving the walker ready for the next frame.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      dig_idx_q <= '0;
      row_idx_q <= '0;
      col_idx_q <= '0;
    end else if (fill_en) begin
      if (col_last) begin
        col_idx_q <= '0;
        if (row_last) begin
          row_idx_q <= '0;
          dig_idx_q <= dig_idx_q + 1'b1;
        end else begin
          row_idx_q <= row_idx_q + 1'b1;
        end
      end else begin
        col_idx_q <= col_idx_q + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Random source: holds in IDLE so the byte sequence is fully deterministic.
  // -------------------------------------------------------------------------
  lfsr_byte_step u_lfsr_byte_step (
    .cur_state  (lfsr_q),
    .next_state (lfsr_next)
  );

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      lfsr_q <= LFSR_SEED;
    end else if (fill_en) begin
      lfsr_q <= lfsr_next;
    end
  end

  // -------------------------------------------------------------------------
  // Frame buffer: the current slot takes the fresh byte; all other slots keep
  // their previous-frame value, so the picture updates progressively.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      // NOTE: this storage is reset because the display must show blank
      // digits straight out of reset; it therefore maps to flops, not RAM.
      for (int d = 0; d < NUM_DIGITS; d++) begin
        for (int r = 0; r < DISP_ROWS; r++) begin
          for (int c = 0; c < DISP_COLUMNS; c++) begin
            frame_q[d][r][c] <= '0;
          end
        end
      end
    end else if (fill_en) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        for (int r = 0; r < DISP_ROWS; r++) begin
          for (int c = 0; c < DISP_COLUMNS; c++) begin
            if (dig_idx_q == DIG_W'(d) && row_idx_q == ROW_W'(r) && col_idx_q == COL_W'(c)) begin
              frame_q[d][r][c] <= lfsr_next[DATA_W-1:0];
            end
          end
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output words: constant address/header nibbles around registered bytes.
  // -------------------------------------------------------------------------
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    for (genvar r = 0; r < DISP_ROWS; r++) begin : g_row
      for (genvar c = 0; c < DISP_COLUMNS; c++) begin : g_col
        assign o_MAX7219_DataStream[d][r][c] = digit_cmd(d, frame_q[d][r][c]);
      end
    end
  end

endmodule

// File: tb/tb_pattern_random.sv
// ---------------------------------------------------------------------------
// tb_pattern_random
// Two instances: A = 1x1 display with an 8-cycle tick, B = 2x2 display with a
// 16-cycle tick. Expected frames come from an independent LFSR model and
// hand-derived frame timing, counted in clock edges since reset release.
//   A: tick at edge 8, writes at edges 9..16; the tick at edge 16 falls in
//      FILL and is dropped, so frames repeat every 16 edges.
//   B: tick at edge 16, writes at edges 17..48; ticks at 32 and 48 fall in
//      FILL and are dropped, so frames repeat every 48 edges.
// ---------------------------------------------------------------------------
module tb_pattern_random;

  localparam logic [31:0] SEED = 32'hACE1_2468;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic clk;
  logic rst_a_n;
  logic rst_b_n;
  logic [0:7][0:0][0:0][15:0] ds_a;
  logic [0:7][1:0][1:0][15:0] ds_b;

  int checks;
  int failures;

  logic [7:0]  exp_a [8];
  logic [7:0]  exp_b [8][2][2];
  logic [31:0] mdl_a;
  logic [31:0] mdl_b;

  pattern_random #(
    .DISP_ROWS    (1),
    .DISP_COLUMNS (1),
    .CLK_FREQ_HZ  (8)
  ) dut_a (
    .i_Clk                (clk),
    .i_Rst                (rst_a_n),
    .o_MAX7219_DataStream (ds_a)
  );

  pattern_random #(
    .DISP_ROWS    (2),
    .DISP_COLUMNS (2),
    .CLK_FREQ_HZ  (16)
  ) dut_b (
    .i_Clk                (clk),
    .i_Rst                (rst_b_n),
    .o_MAX7219_DataStream (ds_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- model ----------------
  function automatic logic [31:0] model_byte_step(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    for (int i = 0; i < 8; i++) begin
      if (r[0]) r = (r >> 1) ^ TAPS;
      else      r = r >> 1;
    end
    return r;
  endfunction

  function automatic logic [15:0] exp_word(input int d, input logic [7:0] b);
    logic [3:0] a;
    a = 4'(d + 1);
    return {4'h0, a, b};
  endfunction

  task automatic model_reset_a();
    mdl_a = SEED;
    for (int d = 0; d < 8; d++) exp_a[d] = 8'h00;
  endtask

  task automatic model_reset_b();
    mdl_b = SEED;
    for (int d = 0; d < 8; d++)
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++) exp_b[d][r][c] = 8'h00;
  endtask

  // t = clock edge number since reset release.
  task automatic model_edge_a(input int t);
    int k;
    if (t > 8) begin
      k = (t - 9) % 16;
      if (k < 8) begin
        mdl_a = model_byte_step(mdl_a);
        exp_a[k] = mdl_a[7:0];
      end
    end
  endtask

  task automatic model_edge_b(input int t);
    int k;
    if (t > 16) begin
      k = (t - 17) % 48;
      if (k < 32) begin
        mdl_b = model_byte_step(mdl_b);
        exp_b[k / 4][(k / 2) % 2][k % 2] = mdl_b[7:0];
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    repeat (5) begin
      @(negedge clk);
      for (int d = 0; d < 8; d++) begin
        checks++;
        if (ds_a[d][0][0] !== exp_word(d, 8'h00)) begin
          failures++;
          $display("FAIL reset_a digit=%0d got=%h exp=%h", d, ds_a[d][0][0], exp_word(d, 8'h00));
        end
        for (int r = 0; r < 2; r++) begin
          for (int c = 0; c < 2; c++) begin
            checks++;
            if (ds_b[d][r][c] !== exp_word(d, 8'h00)) begin
              failures++;
              $display("FAIL reset_b d=%0d r=%0d c=%0d got=%h exp=%h",
                       d, r, c, ds_b[d][r][c], exp_word(d, 8'h00));
            end
          end
        end
      end
    end
  endtask

  task automatic test_first_frame();
    rst_a_n = 1'b1;
    model_reset_a();
    for (int t = 1; t <= 16; t++) begin
      @(negedge clk);
      model_edge_a(t);
      for (int d = 0; d < 8; d++) begin
        checks++;
        if (ds_a[d][0][0] !== exp_word(d, exp_a[d])) begin
          failures++;
          $display("FAIL first_frame t=%0d digit=%0d got=%h exp=%h",
                   t, d, ds_a[d][0][0], exp_word(d, exp_a[d]));
        end
      end
    end
  endtask

  task automatic test_frames();
    // Continues from test_first_frame: frames 2..4 written at 25..32, 41..48, 57..64.
    for (int t = 17; t <= 72; t++) begin
      @(negedge clk);
      model_edge_a(t);
      for (int d = 0; d < 8; d++) begin
        checks++;
        if (ds_a[d][0][0] !== exp_word(d, exp_a[d])) begin
          failures++;
          $display("FAIL frames t=%0d digit=%0d got=%h exp=%h",
                   t, d, ds_a[d][0][0], exp_word(d, exp_a[d]));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    rst_a_n = 1'b0;
    @(negedge clk);
    rst_a_n = 1'b1;
    model_reset_a();
    for (int t = 1; t <= 12; t++) begin
      @(negedge clk);
      model_edge_a(t);
    end
    // Mid-FILL: slots 0..3 written; sanity check one written slot first.
    checks++;
    if (ds_a[3][0][0] !== exp_word(3, exp_a[3])) begin
      failures++;
      $display("FAIL pre_abort digit=3 got=%h exp=%h", ds_a[3][0][0], exp_word(3, exp_a[3]));
    end
    @(posedge clk);
    #2;
    rst_a_n = 1'b0;
    #1;
    for (int d = 0; d < 8; d++) begin
      checks++;
      if (ds_a[d][0][0] !== exp_word(d, 8'h00)) begin
        failures++;
        $display("FAIL async_abort digit=%0d got=%h exp=%h", d, ds_a[d][0][0], exp_word(d, 8'h00));
      end
    end
    repeat (2) @(negedge clk);
    rst_a_n = 1'b1;
    model_reset_a();
    for (int t = 1; t <= 16; t++) begin
      @(negedge clk);
      model_edge_a(t);
      for (int d = 0; d < 8; d++) begin
        checks++;
        if (ds_a[d][0][0] !== exp_word(d, exp_a[d])) begin
          failures++;
          $display("FAIL after_abort t=%0d digit=%0d got=%h exp=%h",
                   t, d, ds_a[d][0][0], exp_word(d, exp_a[d]));
        end
      end
    end
  endtask

  task automatic test_2x2();
    rst_b_n = 1'b1;
    model_reset_b();
    for (int t = 1; t <= 72; t++) begin
      @(negedge clk);
      model_edge_b(t);
      for (int d = 0; d < 8; d++) begin
        for (int r = 0; r < 2; r++) begin
          for (int c = 0; c < 2; c++) begin
            checks++;
            if (ds_b[d][r][c] !== exp_word(d, exp_b[d][r][c])) begin
              failures++;
              $display("FAIL grid_2x2 t=%0d d=%0d r=%0d c=%0d got=%h exp=%h",
                       t, d, r, c, ds_b[d][r][c], exp_word(d, exp_b[d][r][c]));
            end
          end
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_a_n  = 1'b0;
    rst_b_n  = 1'b0;
    test_reset();
    test_first_frame();
    test_frames();
    test_async_reset();
    test_2x2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pattern_random.md
PATTERN_RANDOM -- requirements
Module: pattern_random

Interface
REQ-001 Parameter DISP_ROWS, default 1: number of MAX7219 device rows in the display matrix (>=1).
REQ-002 Parameter DISP_COLUMNS, default 1: number of MAX7219 devices per row (>=1).
REQ-003 Parameter CLK_FREQ_HZ, default 100_000_000: i_Clk frequency in Hz; one new random frame per CLK_FREQ_HZ cycles (1 s); legal range >=1.
REQ-004 i_Clk  input  1  single design clock; all state on rising edge.
REQ-005 i_Rst  input  1  reset, asynchronous, active-low.
REQ-006 o_MAX7219_DataStream  output  [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][15:0]  per digit d (0..7), per device (row, column): one MAX7219 command word.

Function
REQ-007 Each output word SHALL be {4'h0, addr[3:0], data[7:0]} with addr = d+1 (digit registers 1..8); bits [15:8] are constant per digit index.
REQ-008 data[7:0] of every word SHALL come from a registered frame buffer of 8*DISP_ROWS*DISP_COLUMNS bytes; outputs are driven directly from registers (no combinational path from inputs).
REQ-009 Random source SHALL be a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1 (right-shift, tap mask 32'h8020_0003), seed 32'hACE1_2468 at reset; never all-zero.
REQ-010 One "byte step" SHALL advance the LFSR 8 single-bit shifts in one clock (combinational unroll); the written byte is the low 8 bits of the LFSR state after those 8 shifts.
REQ-011 Tick counter SHALL count 0..CLK_FREQ_HZ-1 and wrap; a tick occurs in the cycle where counter == CLK_FREQ_HZ-1.
REQ-012 States: IDLE, FILL. IDLE -> FILL on tick; FILL -> IDLE after the last slot is written.
REQ-013 In FILL, slot index k (0..8*R*C-1) SHALL increment by one per clock; slot k maps to digit d = k / (R*C), row r = (k / C) % R, column c = k % C.
REQ-014 Each FILL cycle SHALL perform one byte step and write that byte into slot k on the same edge; slot 0 written on the first edge after the tick edge; full frame complete 8*R*C cycles after the tick.
REQ-015 A tick arriving while in FILL SHALL be ignored (no restart, no queuing); tick counter keeps running independently.
REQ-016 LFSR SHALL advance only during FILL; in IDLE it holds, so the byte sequence is deterministic and identical across runs.
REQ-017 Slots not yet rewritten during FILL keep their previous-frame value (frame updates progressively, no blanking).

Reset
REQ-018 While i_Rst = 0: tick counter = 0, state = IDLE, slot index = 0, LFSR = seed, all frame bytes = 8'h00, so every output word = {4'h0, d+1, 8'h00}.
REQ-019 Reset assertion mid-FILL SHALL abort immediately (asynchronous) to the REQ-018 values; first tick after release occurs CLK_FREQ_HZ cycles after release.

Structure
REQ-020 Shared package SHALL hold the LFSR width, tap mask, seed, the state enum (IDLE/FILL), and the command-word field widths (addr 4, data 8).
REQ-021 One sub-module lfsr_byte_step SHALL implement the combinational 8-shift LFSR advance (32-bit in, 32-bit next state out); all other logic lives in pattern_random.

Verification
REQ-022 CLK_FREQ_HZ=8, 1x1, hold i_Rst=0 for 5 cycles -> all 8 words = 16'h0100, 16'h0200 ... 16'h0800 throughout.
REQ-023 Same config, release reset -> words unchanged for 8 cycles; tick at counter 7; digit bytes 0..7 update one per cycle over the next 8 cycles, matching a bit-accurate LFSR model from seed 32'hACE1_2468.
REQ-024 Run 4 frames -> each frame's 8 bytes equal the next 8 model byte steps; addr nibbles stay 1..8; bits [15:12] always 0.
REQ-025 DISP_ROWS=2, DISP_COLUMNS=2, CLK_FREQ_HZ=16 -> FILL lasts 32 cycles; a tick at cycle 16 of FILL is ignored; slot order matches REQ-013.
REQ-026 Assert i_Rst=0 asynchronously mid-FILL (between clock edges) -> outputs return to {0, d+1, 00} without waiting for a clock edge; after release the first frame equals the first frame of REQ-023.
